// File: rtl/cnn_pkg.sv
// Shared types and sizes for the binary CNN pipeline.
// Image geometry, frame type and a counter-width helper.
package cnn_pkg;

  localparam int IMG_W    = 28;
  localparam int IMG_H    = 28;
  localparam int IMG_BITS = IMG_W * IMG_H;

  typedef logic [IMG_BITS-1:0] image_t;

  // Counter width for n states, never below one bit.
  function automatic int cnt_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/image_bank.sv
// One frame store: word-indexed write, full-width read.
// Ports: clk, rst_n, i_we, i_addr (word slot), i_data, o_image.
module image_bank #(
  parameter int WORD_W = 8,
  parameter int BEATS  = 98,
  parameter int AW     = 7
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_we,
  input  logic [AW-1:0]           i_addr,
  input  logic [WORD_W-1:0]       i_data,
  output logic [WORD_W*BEATS-1:0] o_image
);

  logic [WORD_W*BEATS-1:0] r_mem;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem <= '0;
    end else if (i_we) begin
      for (int k = 0; k < BEATS; k++) begin
        if (i_addr == AW'(k))
          r_mem[k*WORD_W +: WORD_W] <= i_data;
      end
    end
  end

  assign o_image = r_mem;

endmodule

// File: rtl/image_loader.sv
// Input stage: assembles streamed beats into a frame bank and
// hands complete 784-bit images to the conv stage.
// Ports: clk, rst_n; in_valid/in_ready/in_data/in_last (beats);
// img_valid/img_ready/image (frame); frame_err, frame_cnt.
// IMG_LOADER_DOUBLE_BUF_EN defined: two ping-pong banks,
// otherwise a single bank (no load/consume overlap).
module image_loader
  import cnn_pkg::*;
#(
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  parameter int WORD_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WORD_W-1:0]      in_data,
  input  logic                   in_last,
  output logic                   img_valid,
  input  logic                   img_ready,
  output logic [IMG_W*IMG_H-1:0] image,
  output logic                   frame_err,
  output logic [15:0]            frame_cnt
);

  localparam int BITS  = IMG_W * IMG_H;
  localparam int BEATS = BITS / WORD_W;
  localparam int AW    = cnt_bits(BEATS);

`ifdef IMG_LOADER_DOUBLE_BUF_EN
  localparam bit DBL = 1'b1;
`else
  localparam bit DBL = 1'b0;
`endif

  logic [1:0]    r_full;
  logic          r_wr;
  logic          r_rd;
  logic [AW-1:0] r_beat;
  logic          r_err;
  logic [15:0]   r_cnt;

  logic          w_acc;
  logic          w_end;
  logic          w_done;
  logic          w_bad;
  logic          w_rel;
  logic [BITS-1:0] w_img [2];

  assign w_acc  = in_valid && in_ready;
  assign w_end  = (r_beat == AW'(BEATS-1));
  assign w_done = w_acc && w_end && in_last;
  // Early last or missing last both discard the frame.
  assign w_bad  = w_acc && (w_end != in_last);
  assign w_rel  = img_valid && img_ready;

  image_bank #(
    .WORD_W (WORD_W),
    .BEATS  (BEATS),
    .AW     (AW)
  ) u_bank0 (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_we    (w_acc && !r_wr),
    .i_addr  (r_beat),
    .i_data  (in_data),
    .o_image (w_img[0])
  );

`ifdef IMG_LOADER_DOUBLE_BUF_EN
  image_bank #(
    .WORD_W (WORD_W),
    .BEATS  (BEATS),
    .AW     (AW)
  ) u_bank1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_we    (w_acc && r_wr),
    .i_addr  (r_beat),
    .i_data  (in_data),
    .o_image (w_img[1])
  );
`else
  assign w_img[1] = '0;
`endif

  assign in_ready  = !r_full[r_wr];
  assign img_valid = r_full[r_rd];
  assign image     = w_img[r_rd];
  assign frame_err = r_err;
  assign frame_cnt = r_cnt;

  // Completion and release always target different banks,
  // so both updates to r_full may land in one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_full <= '0;
      r_wr   <= 1'b0;
      r_rd   <= 1'b0;
      r_beat <= '0;
      r_err  <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_err <= w_bad;
      if (w_acc) begin
        if (w_end || in_last)
          r_beat <= '0;
        else
          r_beat <= r_beat + 1'b1;
      end
      if (w_done) begin
        r_full[r_wr] <= 1'b1;
        if (DBL)
          r_wr <= ~r_wr;
      end
      if (w_rel) begin
        r_full[r_rd] <= 1'b0;
        if (DBL)
          r_rd <= ~r_rd;
        r_cnt <= r_cnt + 16'd1;
      end
    end
  end

endmodule
